// File: rtl/parking_pkg.sv
// Shared types and defaults for the parking-lot gate scheduler.
package parking_pkg;
  localparam int NUM_GATES_DEF   = 4;
  localparam int OPEN_CYCLES_DEF = 8;

  typedef enum logic [1:0] {IDLE, SERVE, DONE, OPEN} state_t;

  // What a gate asked for, latched at grant time.
  typedef struct packed {
    logic is_exit;
    logic is_uni;
  } gate_req_t;

  function automatic int gate_idx_w(input int n);
    return $clog2(n);
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requesting gate at or after ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_GATES = 4,
  parameter int GW        = 2
) (
  input  logic [NUM_GATES-1:0] req,
  input  logic [GW-1:0]        ptr,
  output logic [NUM_GATES-1:0] grant,
  output logic [GW-1:0]        idx,
  output logic                 any_req
);
  logic          found;
  logic [GW-1:0] j;

  assign any_req = |req;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = '0;
    for (int i = 0; i < NUM_GATES; i++) begin
      j = GW'((int'(ptr) + i) % NUM_GATES);
      if (!found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = j;
      end
    end
  end
endmodule

// File: rtl/gate_scheduler.sv
// Serialises gate entry/exit requests onto the occupancy board, one event at a time,
// then holds the admitted gate's barrier open for OPEN_CYCLES cycles.
module gate_scheduler
  import parking_pkg::*;
#(
  parameter int NUM_GATES   = NUM_GATES_DEF,
  parameter int OPEN_CYCLES = OPEN_CYCLES_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_GATES-1:0] req,
  input  logic [NUM_GATES-1:0] req_exit,
  input  logic [NUM_GATES-1:0] req_uni,
  input  logic                 uni_is_vacated_space,
  input  logic                 is_vacated_space,
  output logic                 car_entered,
  output logic                 is_uni_car_entered,
  output logic                 car_exited,
  output logic                 is_uni_car_exited,
  output logic [NUM_GATES-1:0] ack,
  output logic [NUM_GATES-1:0] deny,
  output logic [NUM_GATES-1:0] barrier_open,
  output logic                 busy
);
  localparam int GW = (gate_idx_w(NUM_GATES) > 0) ? gate_idx_w(NUM_GATES) : 1;
  localparam int CW = $clog2(OPEN_CYCLES + 1);

  state_t               state, nxt;
  logic [GW-1:0]        ptr, gate_q, grant_idx;
  logic [NUM_GATES-1:0] grant, gate_oh;
  logic                 any_req, admit_q, admit_d;
  gate_req_t            lat_q;
  logic [CW-1:0]        cnt;

  rr_arbiter #(.NUM_GATES(NUM_GATES), .GW(GW)) u_arb (
    .req     (req),
    .ptr     (ptr),
    .grant   (grant),
    .idx     (grant_idx),
    .any_req (any_req)
  );

  // University cars overflow into public space, so either flag admits them.
  assign admit_d = lat_q.is_exit |
                   (lat_q.is_uni ? (uni_is_vacated_space | is_vacated_space) : is_vacated_space);

  assign gate_oh      = NUM_GATES'(1) << gate_q;
  assign barrier_open = (state == OPEN) ? gate_oh : '0;
  assign busy         = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (any_req) nxt = SERVE;
      SERVE:   nxt = DONE;
      DONE:    nxt = admit_q ? OPEN : IDLE;
      OPEN:    if (cnt == CW'(OPEN_CYCLES - 1)) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr                <= '0;
      gate_q             <= '0;
      lat_q              <= '0;
      admit_q            <= 1'b0;
      cnt                <= '0;
      ack                <= '0;
      deny               <= '0;
      car_entered        <= 1'b0;
      is_uni_car_entered <= 1'b0;
      car_exited         <= 1'b0;
      is_uni_car_exited  <= 1'b0;
    end else begin
      ack                <= '0;
      deny               <= '0;
      car_entered        <= 1'b0;
      is_uni_car_entered <= 1'b0;
      car_exited         <= 1'b0;
      is_uni_car_exited  <= 1'b0;
      case (state)
        IDLE: if (any_req) begin
          gate_q        <= grant_idx;
          lat_q.is_exit <= |(grant & req_exit);
          lat_q.is_uni  <= |(grant & req_uni);
        end
        // Decision is frozen here; later flag changes cannot undo it.
        SERVE: begin
          admit_q            <= admit_d;
          ack                <= admit_d ? gate_oh : '0;
          deny               <= admit_d ? '0 : gate_oh;
          car_entered        <= admit_d & ~lat_q.is_exit;
          is_uni_car_entered <= admit_d & ~lat_q.is_exit & lat_q.is_uni;
          car_exited         <= admit_d & lat_q.is_exit;
          is_uni_car_exited  <= admit_d & lat_q.is_exit & lat_q.is_uni;
        end
        DONE: begin
          ptr <= (gate_q == GW'(NUM_GATES - 1)) ? '0 : gate_q + GW'(1);
          cnt <= '0;
        end
        OPEN:    cnt <= cnt + CW'(1);
        default: ;
      endcase
    end
  end
endmodule

// File: doc/gate_scheduler.md
Name: gate_scheduler

Overview:
- Sequences all parking-lot gates onto the single occupancy board.
- Each gate raises an entry or exit request. A round-robin arbiter serialises the requests and checks the board's vacancy flags.
- It emits exactly one single-cycle car_entered or car_exited pulse per admitted car, then holds that gate's barrier open for a fixed time.
- Sits between the gate sensors and the occupancy board; the board's counters only ever see one event per cycle.

Parameters:
- NUM_GATES, 4, number of gates (each can request entry or exit).
- OPEN_CYCLES, 8, cycles barrier_open stays high after an admit (must be at least 1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  NUM_GATES  per-gate request level, held until ack or deny.
- req_exit  in  NUM_GATES  per-gate kind: 1 = exit, 0 = entry; valid while req is high.
- req_uni  in  NUM_GATES  per-gate car class: 1 = university, 0 = public; valid while req is high.
- uni_is_vacated_space  in  1  board flag: university space available.
- is_vacated_space  in  1  board flag: public space available.
- car_entered  out  1  one-cycle entry event to the board.
- is_uni_car_entered  out  1  class of the entry; qualified by car_entered.
- car_exited  out  1  one-cycle exit event to the board.
- is_uni_car_exited  out  1  class of the exit; qualified by car_exited.
- ack  out  NUM_GATES  one-cycle "request accepted" pulse, one-hot.
- deny  out  NUM_GATES  one-cycle "lot full" pulse, one-hot.
- barrier_open  out  NUM_GATES  barrier drive, at most one bit high.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset (asynchronous, any state):
  - state = IDLE, round-robin pointer = 0, latched gate/kind/class = 0, open counter = 0.
  - All outputs = 0.
  - A request in flight is dropped silently; its requester keeps req high and is re-arbitrated after reset is released.
- Reset dominates every other input.
- FSM states: IDLE, SERVE, DONE, OPEN.
- IDLE:
  - At an edge where any req bit is high, choose the first gate g at or after the pointer, wrapping modulo NUM_GATES.
  - Latch g, req_exit[g] and req_uni[g], then go to SERVE.
  - If no req bit is high, stay in IDLE.
- SERVE (one cycle): sample the vacancy flags and set the admit decision.
  - Exit: always admit.
  - Public entry: admit if is_vacated_space = 1.
  - University entry: admit if uni_is_vacated_space = 1 or is_vacated_space = 1. The board overflows university cars into public space.
  - Go to DONE.
- DONE (one cycle): outputs are registered and high only during this cycle.
  - Admit: ack[g] = 1, plus car_entered or car_exited = 1, with the matching is_uni_* = latched class.
  - Deny: deny[g] = 1 only; no board event.
  - Pointer = (g + 1) mod NUM_GATES on both admit and deny.
  - Next state: OPEN on admit, IDLE on deny.
- OPEN:
  - barrier_open[g] = 1 for exactly OPEN_CYCLES cycles; counter counts 0 .. OPEN_CYCLES-1.
  - req is ignored while in OPEN.
  - Then go to IDLE.
- Latency from req sampled high in IDLE at edge 0:
  - Pulses during cycle 2.
  - Barrier open during cycles 3 .. 2+OPEN_CYCLES.
  - Next grant is sampled at edge 3+OPEN_CYCLES after an admit, or at edge 3 after a deny.
- Requester rule: deassert req at the edge that ends the ack/deny cycle. The scheduler does not sample req during SERVE, DONE or OPEN, so there is no double grant.
- Board spacing: board events are at least 3 cycles apart, so the vacancy flags are settled when next sampled in SERVE.
- Simultaneous requests: entry and exit requests on different gates are serialised in round-robin order. Exit is not prioritised over entry.
- An hour change after SERVE does not alter a decision already taken.
- A gate that keeps req high after a deny is re-served only after all other requesting gates have been served (fairness).
- Widths: gate index is $clog2(NUM_GATES) bits; open counter is $clog2(OPEN_CYCLES+1) bits.

Decomposition:
- parking_pkg holds:
  - the state enum (IDLE, SERVE, DONE, OPEN);
  - default constants NUM_GATES_DEF = 4 and OPEN_CYCLES_DEF = 8;
  - the function gate_idx_w(n) = $clog2(n).
- One sub-module, rr_arbiter:
  - combinational one-hot grant from the req vector and the pointer, plus an encoded index and any_req.
  - The FSM, latches and counter stay in gate_scheduler.

Test Plan:
- Reset, then req[1]=1 with exit=0, uni=0 and is_vacated_space=1 → car_entered=1 and ack[1]=1 in cycle 2 only, is_uni_car_entered=0, barrier_open[1] high in cycles 3..10, then busy=0.
- req[2] as a university entry with uni_is_vacated_space=0 and is_vacated_space=1 → admitted with is_uni_car_entered=1. Repeat with both flags 0 → deny[2]=1 for one cycle, no car_entered, barrier stays 0, IDLE at cycle 3.
- req[0..3] all high at edge 0, pointer=0, all gates admitted → grants in order 0,1,2,3, with ack pulses at cycles 2, 13, 24, 35.
- req[3] as an exit with both vacancy flags 0 → still admitted: car_exited=1, is_uni_car_exited = req_uni[3].
- Reset asserted during OPEN at cycle 5 → barrier_open and busy = 0 immediately (asynchronous). With req[1] held, a new grant follows reset release, and the pointer restarts at 0.
- Gate 0 denied and keeping req high while gate 1 is requesting → gate 1 is served before gate 0 is re-served.
